// File: rtl/demux1to4_2bit_frame_pkg.sv
// Shared slot codes and FSM states for the 2-bit frame demux
// and its companion 4-to-1 selector.
package demux1to4_2bit_frame_pkg;

  localparam logic [1:0] SLOT_U = 2'b00;
  localparam logic [1:0] SLOT_V = 2'b01;
  localparam logic [1:0] SLOT_W = 2'b10;
  localparam logic [1:0] SLOT_X = 2'b11;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/demux1to4_2bit_frame_slot_reg.sv
// One held output slot: WIDTH-bit register with write enable
// and asynchronous active-low clear.
module slot_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/demux1to4_2bit_frame.sv
// Registered 1-to-4 demux: collects four symbols into slots
// u..x and holds the frame until the consumer acks.
module demux1to4_2bit_frame
  import demux1to4_2bit_frame_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             sel_mode,
  input  logic [1:0]       sel,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] x,
  output logic             frame_valid,
  output logic [1:0]       ptr,
  output logic [3:0]       fill
);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] fill_q, fill_d;
  logic [1:0] tgt;
  logic       acc;
  logic [3:0] we;

  assign in_ready    = (state_q == ST_LOAD);
  assign frame_valid = (state_q == ST_HOLD);
  assign acc         = in_valid & in_ready;
  assign tgt         = sel_mode ? sel : ptr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_LOAD;
      ptr_q   <= 2'b00;
      fill_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    we      = 4'b0000;
    unique case (state_q)
      ST_LOAD: begin
        if (acc) begin
          unique case (tgt)
            SLOT_U: we = 4'b0001;
            SLOT_V: we = 4'b0010;
            SLOT_W: we = 4'b0100;
            SLOT_X: we = 4'b1000;
          endcase
          fill_d = fill_q | we;
          if (!sel_mode) ptr_d = ptr_q + 2'd1;
          if (fill_d == 4'b1111) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // slot contents survive the ack; only bookkeeping resets
        if (frame_ack) begin
          state_d = ST_LOAD;
          ptr_d   = 2'b00;
          fill_d  = 4'b0000;
        end
      end
    endcase
  end

  slot_reg #(.WIDTH(WIDTH)) u_slot_u (
    .clk_i(clk), .rst_ni(resetn), .we_i(we[0]), .d_i(d), .q_o(u)
  );
  slot_reg #(.WIDTH(WIDTH)) u_slot_v (
    .clk_i(clk), .rst_ni(resetn), .we_i(we[1]), .d_i(d), .q_o(v)
  );
  slot_reg #(.WIDTH(WIDTH)) u_slot_w (
    .clk_i(clk), .rst_ni(resetn), .we_i(we[2]), .d_i(d), .q_o(w)
  );
  slot_reg #(.WIDTH(WIDTH)) u_slot_x (
    .clk_i(clk), .rst_ni(resetn), .we_i(we[3]), .d_i(d), .q_o(x)
  );

  assign ptr  = ptr_q;
  assign fill = fill_q;

endmodule
